// File: rtl/spi_burst_sequencer.sv
// spi_burst_sequencer: runs one SPI burst by driving the SPI master's MMIO port
// Ports:
//   clk, resetn                         clock, async active-low reset
//   cmd_valid/ready, cmd_len/cfg/keep_cs/fill   burst command handshake
//   tx_valid/ready, tx_data             TX byte stream in
//   rx_valid/ready, rx_data             RX byte stream out
//   m_valid/write/addr/wdata/wstrb, m_rdata, m_ready   MMIO master to SPI peripheral
//   busy, done, err                     burst status (err sticky until next accept)
module spi_burst_sequencer #(
  parameter logic [31:0] BASE_ADDR = 32'h8000_0050,
  parameter int LEN_W = 8,
  parameter int TMO_W = 12
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [LEN_W-1:0] cmd_len,
  input  logic [4:0]       cmd_cfg,
  input  logic             cmd_keep_cs,
  input  logic             cmd_fill,
  input  logic             tx_valid,
  input  logic [7:0]       tx_data,
  output logic             tx_ready,
  output logic             rx_valid,
  output logic [7:0]       rx_data,
  input  logic             rx_ready,
  output logic             m_valid,
  output logic             m_write,
  output logic [31:0]      m_addr,
  output logic [31:0]      m_wdata,
  output logic [3:0]       m_wstrb,
  input  logic [31:0]      m_rdata,
  input  logic             m_ready,
  output logic             busy,
  output logic             done,
  output logic             err
);
  typedef enum logic [3:0] {IDLE, CFG, CSLO, GETTX, TXW, GAP, POLL, RDD, PUSH, CSHI, ABORT, FIN} state_t;
  state_t state, nxt;
  logic [LEN_W-1:0] rem;
  logic [4:0] cfg_r;
  logic keep_r, fill_r;
  logic [7:0] tx_byte;
  logic [TMO_W-1:0] tmo_cnt;
  logic ack, in_tmo, tmo_hit, req, req_wr;
  logic [3:0] req_off;
  logic [31:0] req_wdata;
  state_t end_state;
  assign ack = m_valid && m_ready;
  assign in_tmo = state == TXW || state == GAP || state == POLL;
  assign tmo_hit = in_tmo && (&tmo_cnt);
  assign end_state = keep_r ? FIN : CSHI;
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) state <= IDLE;
    else state <= nxt;
  always_comb begin
    nxt = state;
    case (state)
      IDLE:  nxt = cmd_valid ? CFG : IDLE;
      CFG:   nxt = ack ? CSLO : CFG;
      CSLO:  nxt = !ack ? CSLO : (rem == '0) ? end_state : GETTX;
      GETTX: nxt = (fill_r || tx_valid) ? TXW : GETTX;
      TXW:   nxt = ack ? GAP : TXW;
      GAP:   nxt = POLL;
      POLL:  nxt = (ack && m_rdata[1:0] == 2'b10) ? RDD : POLL;
      RDD:   nxt = ack ? PUSH : RDD;
      PUSH:  nxt = !rx_ready ? PUSH : (rem == LEN_W'(1)) ? end_state : GETTX;
      CSHI:  nxt = ack ? FIN : CSHI;
      // an abandoned request must still see its ack before CS can be released
      ABORT: nxt = (!m_valid || m_ready) ? CSHI : ABORT;
      FIN:   nxt = IDLE;
      default: nxt = IDLE;
    endcase
    if (tmo_hit) nxt = ABORT;
  end
  always_comb begin
    cmd_ready = state == IDLE;
    busy = state != IDLE && state != FIN;
    done = state == FIN;
    tx_ready = state == GETTX && !fill_r && tx_valid;
    rx_valid = state == PUSH;
    req = state == CFG || state == CSLO || state == TXW || state == POLL || state == RDD || state == CSHI;
    req_wr = state == CFG || state == CSLO || state == TXW || state == CSHI;
    req_off = state == CFG ? 4'h0 : (state == CSLO || state == CSHI) ? 4'hC : (state == TXW || state == RDD) ? 4'h4 : 4'h8;
    req_wdata = state == CFG ? {27'b0, cfg_r} : state == TXW ? {24'b0, tx_byte} : state == CSHI ? 32'd1 : 32'd0;
  end
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) begin
      rem <= '0;
      cfg_r <= '0;
      keep_r <= 1'b0;
      fill_r <= 1'b0;
      tx_byte <= '0;
      tmo_cnt <= '0;
      err <= 1'b0;
      rx_data <= '0;
      m_valid <= 1'b0;
      m_write <= 1'b0;
      m_addr <= '0;
      m_wdata <= '0;
      m_wstrb <= '0;
    end else begin
      if (state == IDLE && cmd_valid) begin
        rem <= cmd_len;
        cfg_r <= cmd_cfg;
        keep_r <= cmd_keep_cs;
        fill_r <= cmd_fill;
        err <= 1'b0;
      end
      if (state == GETTX) begin
        tmo_cnt <= '0;
        tx_byte <= fill_r ? 8'hFF : tx_data;
      end else if (in_tmo) tmo_cnt <= tmo_cnt + 1'b1;
      if (tmo_hit) err <= 1'b1;
      if (state == RDD && ack) rx_data <= m_rdata[7:0];
      if (state == PUSH && rx_ready) rem <= rem - 1'b1;
      // ack drops m_valid, so every request is separated by at least one idle cycle
      if (ack) m_valid <= 1'b0;
      else if (req && !m_valid && !tmo_hit) begin
        m_valid <= 1'b1;
        m_write <= req_wr;
        m_addr <= BASE_ADDR + {28'b0, req_off};
        m_wdata <= req_wdata;
        m_wstrb <= req_wr ? 4'b0001 : 4'b0000;
      end
    end
endmodule

// File: doc/spi_burst_sequencer.md
Name: spi_burst_sequencer

Overview:
- Hardware sequencer that drives the existing SPI master peripheral through its MMIO slave port, so the CPU does not have to byte-poll.
- Accepts one burst command: clock config, byte count, CS policy and fill mode.
- Streams TX bytes in, performs each 8-bit transfer, and streams RX bytes out.
- Sits between a command/stream front end (CPU-facing wrapper or boot loader) and the SPI master's MMIO inputs, and is the sole MMIO master of that peripheral.

Parameters:
- BASE_ADDR, 32'h80000050: SPI master base. CTRL=+0x0, DATA=+0x4, STATUS=+0x8, CS=+0xC.
- LEN_W, 8: width of cmd_len.
- TMO_W, 12: width of the per-byte poll timeout counter. Timeout occurs after 2^TMO_W-1 cycles.

Ports:
- clk  in  1  system clock (50 MHz)
- resetn  in  1  asynchronous active-low reset
- cmd_valid  in  1  burst command request
- cmd_ready  out  1  sequencer idle, command accepted when valid&&ready
- cmd_len  in  LEN_W  number of bytes (0 = config/CS only)
- cmd_cfg  in  5  {clk_div[2:0],cpha,cpol} written to CTRL
- cmd_keep_cs  in  1  1 = leave CS low after burst
- cmd_fill  in  1  1 = send 8'hFF, ignore tx stream
- tx_valid  in  1  TX byte available
- tx_data  in  8  TX byte
- tx_ready  out  1  TX byte consumed
- rx_valid  out  1  RX byte available
- rx_data  out  8  RX byte
- rx_ready  in  1  downstream accepts RX byte
- m_valid  out  1  MMIO request to SPI master
- m_write  out  1  MMIO write
- m_addr  out  32  MMIO address
- m_wdata  out  32  MMIO write data
- m_wstrb  out  4  MMIO strobes (4'b0001 on writes, 0 on reads)
- m_rdata  in  32  MMIO read data
- m_ready  in  1  MMIO ack (one-cycle pulse)
- busy  out  1  burst in progress
- done  out  1  one-cycle pulse at burst end
- err  out  1  sticky timeout flag, cleared on next command accept

Behaviour:
- Reset values: all outputs 0 except cmd_ready=1. State = IDLE, counters = 0.
- Clock and reset: single clock. Asynchronous active-low reset. Reset mid-burst returns to IDLE immediately and issues no CS release; the SPI master's own reset restores CS high.
- MMIO rule: all m_* outputs are registered. m_valid is held with stable addr/data until m_ready is sampled high, then dropped the next cycle. Back-to-back requests need at least one cycle with m_valid low.
- A DATA write may be held unacked for arbitrary cycles while the master is busy. The sequencer keeps m_valid asserted; this is not an error.
- States:
  - IDLE: cmd_ready=1. On accept: latch the command, clear err, busy=1, go to CFG.
  - CFG: write CTRL with wdata = {27'b0, cmd_cfg}.
  - CSLO: write CS with 0.
  - If len==0: go to CSHI, or to FIN when keep_cs=1. Otherwise go to GETTX.
  - GETTX: if fill, use 8'hFF. Else wait for tx_valid; tx_ready pulses for exactly one cycle to pop the byte.
  - TXW: write DATA with {24'b0, byte}.
  - GAP: exactly one idle cycle after the DATA ack, so STATUS is never sampled before the master clears done.
  - POLL: read STATUS repeatedly until rdata[1:0]==2'b10 (done=1, busy=0).
  - RDD: read DATA; latch rdata[7:0].
  - PUSH: rx_valid=1 holding the byte until rx_ready. Decrement the remaining count. If remaining != 0 go to GETTX, else go to CSHI, or to FIN when keep_cs=1.
  - CSHI: write CS with 1.
  - FIN: done pulses 1 cycle, busy=0, return to IDLE.
- Timeout: the counter resets on entry to TXW and counts every cycle in TXW/GAP/POLL. On reaching all-ones: set err, abandon the burst, drop m_valid cleanly (wait for any outstanding m_ready first), go to CSHI regardless of keep_cs, then FIN. Timeout applies only in TXW/GAP/POLL; RDD is not counted.
- rx_valid stalls do not time out; the SPI link simply idles with CS held.
- cmd_valid arriving while busy is ignored (cmd_ready=0).
- Byte count: cmd_len is unsigned, max 2^LEN_W-1. The count is decremented only in PUSH, so it never wraps.

Test Plan:
- cfg=5'b111_0_0, len=3, fill=0, keep_cs=0, tx A5,3C,0F, slave model echoes the previous byte → MMIO trace CTRL=0x1C, CS=0, 3×(DATA, STATUS polls, DATA read), CS=1. RX bytes 00,A5,3C. done pulses once. err=0.
- len=2, fill=1, keep_cs=1 → DATA writes 0xFF twice, tx_ready never asserts, no final CS write, SPI CS remains 0.
- len=0, keep_cs=0 → exactly three MMIO writes (CTRL, CS=0, CS=1), done at end, no tx/rx activity.
- rx_ready held low for 200 cycles on byte 1 of 2 → no MMIO traffic during the stall, no err, and the burst completes normally once rx_ready rises.
- Stuck peripheral (STATUS always returns 1), TMO_W=4 → err=1 about 15 cycles after the DATA ack, CS=1 written, done pulses, next command accept clears err.
- Assert resetn low mid-POLL → next cycle m_valid=0, busy=0, cmd_ready=1. After release, a new len=1 burst completes correctly.
